sd_data_rx: RTL and testbench

Receive-side DAT-line engine of the SD host controller. It waits for a block start bit on the SD DAT lines, deserialises one data block in 1-bit or 4-bit bus mode, and streams it as 4-bit nibbles with a write strobe into the RX FIFO, which packs them into 32-bit words. It checks the per-line CRC16 and end bit, applies a start-bit timeout, and reports completion and error status to the controller's command/status logic.

---
 rtl/sd_data_rx_if.sv | 30 +++
 rtl/sd_data_rx.sv | 138 +++++++++++++
 tb/tb_sd_data_rx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_data_rx_if.sv
// Signal bundle between the SD controller and the DAT-line receive engine:
// block control, sampled DAT lines, RX FIFO strobe and completion status.
interface sd_data_rx_if #(
  parameter int BLKSIZE_W = 12,
  parameter int TIMEOUT_W = 16
);
  logic                 start_i;
  logic [BLKSIZE_W-1:0] blksize_i;
  logic                 bus_4bit_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic [3:0]           dat_i;
  logic                 fifo_full_i;
  logic [3:0]           data_o;
  logic                 wr_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 crc_err_o;
  logic                 timeout_o;
  logic                 overrun_o;

  modport master (
    output start_i, blksize_i, bus_4bit_i, timeout_i, dat_i, fifo_full_i,
    input  data_o, wr_o, busy_o, done_o, crc_err_o, timeout_o, overrun_o
  );

  modport slave (
    input  start_i, blksize_i, bus_4bit_i, timeout_i, dat_i, fifo_full_i,
    output data_o, wr_o, busy_o, done_o, crc_err_o, timeout_o, overrun_o
  );
endinterface

// File: rtl/sd_data_rx.sv
// SD DAT-line block receiver: start-bit wait with timeout, 1/4-bit deserialisation
// into FIFO nibbles, per-line CRC16 and end-bit checking.
module sd_data_rx #(
  parameter int BLKSIZE_W = 12,
  parameter int TIMEOUT_W = 16
) (
  input logic         sd_clk,
  input logic         rst,
  sd_data_rx_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
  } state_t;

  state_t               state, state_next;
  logic                 four;
  logic [BLKSIZE_W-1:0] blk;
  logic [TIMEOUT_W-1:0] tmo;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [BLKSIZE_W:0]   nib_cnt;
  logic [BLKSIZE_W:0]   nib_last;
  logic [1:0]           bit_cnt;
  logic [3:0]           crc_cnt;
  logic [2:0]           shreg;
  logic [15:0]          crc [4];
  logic [3:0]           act;
  logic [3:0]           nib_val;
  logic                 accept;
  logic                 start_bit;
  logic                 tmo_hit;
  logic                 nib_done;
  logic                 last_nib;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    act       = four ? 4'hF : 4'h1;
    start_bit = four ? (bus.dat_i == 4'h0) : ~bus.dat_i[0];
    tmo_hit   = (tmo != '0) && (wait_cnt == tmo);
    nib_val   = four ? bus.dat_i : {shreg, bus.dat_i[0]};
    nib_done  = (state == S_DATA) && (four || bit_cnt == 2'd3);
    nib_last  = {blk, 1'b0} - (BLKSIZE_W + 1)'(1);
    last_nib  = nib_done && (nib_cnt == nib_last);
    accept    = (state == S_IDLE) && bus.start_i && (bus.blksize_i != '0);
  end

  always_ff @(posedge sd_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (accept) state_next = S_WAIT_START;
      S_WAIT_START: begin
        if (start_bit)    state_next = S_DATA;
        else if (tmo_hit) state_next = S_DONE;
      end
      S_DATA:       if (last_nib) state_next = S_CRC;
      S_CRC:        if (crc_cnt == 4'd15) state_next = S_END;
      S_END:        state_next = S_DONE;
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  assign bus.done_o = (state == S_DONE);
  assign bus.busy_o = (state == S_WAIT_START) || (state == S_DATA) ||
                      (state == S_CRC) || (state == S_END);

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      bus.wr_o      <= 1'b0;
      bus.data_o    <= '0;
      bus.crc_err_o <= 1'b0;
      bus.timeout_o <= 1'b0;
      bus.overrun_o <= 1'b0;
      four          <= 1'b0;
      blk           <= '0;
      tmo           <= '0;
      wait_cnt      <= '0;
      nib_cnt       <= '0;
      bit_cnt       <= '0;
      crc_cnt       <= '0;
      shreg         <= '0;
      for (int unsigned l = 0; l < 4; l++) crc[l[1:0]] <= '0;
    end else begin
      bus.wr_o <= 1'b0;
      if (accept) begin
        four          <= bus.bus_4bit_i;
        blk           <= bus.blksize_i;
        tmo           <= bus.timeout_i;
        bus.crc_err_o <= 1'b0;
        bus.timeout_o <= 1'b0;
        bus.overrun_o <= 1'b0;
        wait_cnt      <= '0;
        nib_cnt       <= '0;
        bit_cnt       <= '0;
        crc_cnt       <= '0;
        for (int unsigned l = 0; l < 4; l++) crc[l[1:0]] <= '0;
      end
      case (state)
        S_WAIT_START: begin
          wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          if (!start_bit && tmo_hit) bus.timeout_o <= 1'b1;
        end
        S_DATA: begin
          bit_cnt <= bit_cnt + 2'd1;
          shreg   <= {shreg[1:0], bus.dat_i[0]};
          for (int unsigned l = 0; l < 4; l++)
            if (act[l[1:0]]) crc[l[1:0]] <= crc_step(crc[l[1:0]], bus.dat_i[l[1:0]]);
          // A full FIFO only suppresses the write; counting and CRC carry on.
          if (nib_done) begin
            nib_cnt <= nib_cnt + (BLKSIZE_W + 1)'(1);
            if (bus.fifo_full_i) begin
              bus.overrun_o <= 1'b1;
            end else begin
              bus.wr_o   <= 1'b1;
              bus.data_o <= nib_val;
            end
          end
        end
        S_CRC: begin
          crc_cnt <= crc_cnt + 4'd1;
          for (int unsigned l = 0; l < 4; l++) begin
            if (act[l[1:0]] && (bus.dat_i[l[1:0]] != crc[l[1:0]][15])) bus.crc_err_o <= 1'b1;
            crc[l[1:0]] <= {crc[l[1:0]][14:0], 1'b0};
          end
        end
        S_END: if ((~bus.dat_i & act) != 4'h0) bus.crc_err_o <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_data_rx.sv
// Randomised bench for sd_data_rx: blocks built from byte arrays, CRCs by polynomial
// long division, expected write/done timing from the block cycle-count rules.
module tb_sd_data_rx;
  localparam int BW = 12;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_data_rx_if #(.BLKSIZE_W(BW), .TIMEOUT_W(TW)) bus ();
  sd_data_rx #(.BLKSIZE_W(BW), .TIMEOUT_W(TW)) dut (.sd_clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] wr_data_q[$];
  int         wr_cyc_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_crc, done_tmo, done_ovr, done_busy;

  logic [7:0] blk [0:15];
  logic       lb [0:3][0:127];
  logic [3:0] exp_nib_q[$];
  int         exp_cyc_q[$];
  int         exp_done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_o === 1'b1) begin
      wr_data_q.push_back(bus.data_o);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.done_o === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_crc  = bus.crc_err_o;
      done_tmo  = bus.timeout_o;
      done_ovr  = bus.overrun_o;
      done_busy = bus.busy_o;
    end
  end

  function automatic logic [3:0] nib_of(input int k);
    logic [7:0] b;
    b = blk[k / 2];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, bit 15 = highest degree.
  function automatic logic [15:0] crc_poly(input int l, input int n);
    logic        m [0:143];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    for (int i = 0; i < n + 16; i++) m[i] = (i < n) ? lb[l][i] : 1'b0;
    for (int i = 0; i < n; i++)
      if (m[i]) for (int t = 0; t < 17; t++) m[i + t] = m[i + t] ^ g[16 - t];
    for (int j = 0; j < 16; j++) r[15 - j] = m[n + j];
    return r;
  endfunction

  task automatic clear_mon();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic rand_blk(input int len);
    for (int i = 0; i < len; i++) blk[i] = 8'($urandom);
  endtask

  task automatic run_block(input bit four, input int len, input int flip_line, input int flip_j,
                           input int bad_end, input int full_nib, input int gap, input bit spur);
    int         nbits, nnib, s, idx;
    logic [15:0] crc [4];
    logic [3:0] d, act;
    nnib  = 2 * len;
    nbits = four ? nnib : 8 * len;
    act   = four ? 4'hF : 4'h1;
    for (int k = 0; k < nbits; k++) begin
      d = nib_of(k);
      for (int l = 0; l < 4; l++) begin
        if (four)        lb[l][k] = d[l];
        else if (l == 0) lb[l][k] = blk[k / 8][7 - (k % 8)];
        else             lb[l][k] = 1'b0;
      end
    end
    for (int l = 0; l < 4; l++) crc[l] = crc_poly(l, nbits);
    clear_mon();
    exp_nib_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    bus.start_i = 1'b1; bus.blksize_i = BW'(len); bus.bus_4bit_i = four;
    bus.timeout_i = '0; bus.dat_i = 4'hF; bus.fifo_full_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0; bus.blksize_i = BW'($urandom); bus.bus_4bit_i = 1'($urandom);
    bus.timeout_i = TW'($urandom_range(1, 3));
    for (int g = 0; g < gap; g++) begin
      if (spur && g == 0) bus.start_i = 1'b1;
      bus.dat_i = four ? 4'($urandom_range(1, 15)) : {3'($urandom), 1'b1};
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    bus.dat_i = four ? 4'h0 : {3'($urandom), 1'b0};
    s = cyc;
    for (int i = 0; i < nnib; i++)
      if (i != full_nib) begin
        exp_nib_q.push_back(nib_of(i));
        exp_cyc_q.push_back(four ? s + 2 + i : s + 5 + 4 * i);
      end
    exp_done_cyc = s + nbits + 18;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      idx = four ? k : k / 4;
      bus.fifo_full_i = (idx == full_nib) && (four || (k % 4 == 3));
      bus.dat_i = four ? nib_of(k) : {3'($urandom), lb[0][k]};
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      bus.fifo_full_i = 1'b0;
      for (int l = 0; l < 4; l++)
        d[l] = act[l] ? (crc[l][15 - j] ^ (l == flip_line && j == flip_j)) : 1'($urandom);
      bus.dat_i = d;
    end
    @(negedge clk);
    bus.fifo_full_i = 1'b0;
    for (int l = 0; l < 4; l++) d[l] = act[l] ? (l != bad_end) : 1'($urandom);
    bus.dat_i = d;
    @(negedge clk);
    bus.dat_i = 4'hF;
    for (int t = 0; t < 64 && done_cnt == 0; t++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.data_o, bus.wr_o, bus.busy_o, bus.done_o, bus.crc_err_o, bus.timeout_o, bus.overrun_o} !== 10'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.data_o, bus.wr_o, bus.busy_o, bus.done_o,
               bus.crc_err_o, bus.timeout_o, bus.overrun_o});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_4bit();
    blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h56; blk[3] = 8'h78;
    run_block(1'b1, 4, -1, 0, -1, -1, 2, 1'b0);
    checks++;
    if (wr_data_q.size() !== 8) begin failures++; $display("FAIL b4_count got=%0d exp=8", wr_data_q.size()); end
    for (int i = 0; i < 8 && i < wr_data_q.size(); i++) begin
      checks++;
      if (wr_data_q[i] !== 4'(i + 1) || wr_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++;
        $display("FAIL b4_nibble%0d got=%h@%0d exp=%h@%0d", i, wr_data_q[i], wr_cyc_q[i], i + 1, exp_cyc_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cyc) begin
      failures++; $display("FAIL b4_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, exp_done_cyc);
    end
    checks++;
    if ({done_crc, done_tmo, done_ovr, done_busy} !== 4'b0000) begin
      failures++; $display("FAIL b4_status got=%b exp=0000", {done_crc, done_tmo, done_ovr, done_busy});
    end
  endtask

  task automatic test_1bit();
    blk[0] = 8'hA5;
    run_block(1'b0, 1, -1, 0, -1, -1, 1, 1'b0);
    checks++;
    if (wr_data_q.size() !== 2) begin failures++; $display("FAIL b1_count got=%0d exp=2", wr_data_q.size()); end
    for (int i = 0; i < 2 && i < wr_data_q.size(); i++) begin
      checks++;
      if (wr_data_q[i] !== exp_nib_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++;
        $display("FAIL b1_nibble%0d got=%h@%0d exp=%h@%0d", i, wr_data_q[i], wr_cyc_q[i], exp_nib_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done_cyc || done_crc !== 1'b0) begin
      failures++;
      $display("FAIL b1_done got=%0d@%0d crc=%b exp=1@%0d crc=0", done_cnt, done_cyc, done_crc, exp_done_cyc);
    end
  endtask

  task automatic test_crc_err();
    rand_blk(4);
    run_block(1'b1, 4, 2, $urandom_range(0, 15), -1, -1, 1, 1'b0);
    checks++;
    if (done_cnt !== 1 || done_crc !== 1'b1 || wr_data_q.size() !== 8) begin
      failures++;
      $display("FAIL crc_flip_dat2 got done=%0d crc=%b wr=%0d exp done=1 crc=1 wr=8", done_cnt, done_crc, wr_data_q.size());
    end
    rand_blk(4);
    run_block(1'b1, 4, -1, 0, 1, -1, 1, 1'b0);
    checks++;
    if (done_cnt !== 1 || done_crc !== 1'b1) begin
      failures++; $display("FAIL crc_end_dat1 got done=%0d crc=%b exp done=1 crc=1", done_cnt, done_crc);
    end
    rand_blk(2);
    run_block(1'b0, 2, 0, $urandom_range(0, 15), -1, -1, 1, 1'b0);
    checks++;
    if (done_cnt !== 1 || done_crc !== 1'b1) begin
      failures++; $display("FAIL crc_flip_1bit got done=%0d crc=%b exp done=1 crc=1", done_cnt, done_crc);
    end
  endtask

  task automatic test_overrun();
    rand_blk(4);
    run_block(1'b1, 4, -1, 0, -1, 3, 1, 1'b0);
    checks++;
    if (wr_data_q.size() !== 7) begin failures++; $display("FAIL ovr_count got=%0d exp=7", wr_data_q.size()); end
    for (int i = 0; i < 7 && i < wr_data_q.size(); i++) begin
      checks++;
      if (wr_data_q[i] !== exp_nib_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++;
        $display("FAIL ovr_nibble%0d got=%h@%0d exp=%h@%0d", i, wr_data_q[i], wr_cyc_q[i], exp_nib_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_ovr !== 1'b1 || done_crc !== 1'b0) begin
      failures++; $display("FAIL ovr_status got done=%0d ovr=%b crc=%b exp 1 1 0", done_cnt, done_ovr, done_crc);
    end
  endtask

  task automatic test_timeout();
    int b;
    clear_mon();
    @(negedge clk);
    bus.start_i = 1'b1; bus.blksize_i = BW'($urandom_range(1, 16)); bus.bus_4bit_i = 1'b1;
    bus.timeout_i = TW'(10); bus.dat_i = 4'hF;
    @(negedge clk);
    bus.start_i = 1'b0;
    b = cyc;
    checks++;
    if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL tmo_busy_rise got=%b exp=1", bus.busy_o); end
    for (int t = 0; t < 40 && done_cnt == 0; t++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt !== 1 || done_cyc !== b + 11 || done_tmo !== 1'b1 || wr_data_q.size() !== 0) begin
      failures++;
      $display("FAIL tmo_10 got done=%0d@%0d tmo=%b wr=%0d exp done=1@%0d tmo=1 wr=0",
               done_cnt, done_cyc, done_tmo, wr_data_q.size(), b + 11);
    end
    checks++;
    if (bus.timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_held got=%b exp=1", bus.timeout_o); end
    clear_mon();
    bus.start_i = 1'b1; bus.bus_4bit_i = 1'($urandom); bus.timeout_i = '0;
    @(negedge clk);
    bus.start_i = 1'b0;
    checks++;
    if (bus.timeout_o !== 1'b0) begin failures++; $display("FAIL tmo_clear_on_start got=%b exp=0", bus.timeout_o); end
    repeat (1000) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || bus.busy_o !== 1'b1 || bus.timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_disabled got done=%0d busy=%b tmo=%b exp 0 1 0", done_cnt, bus.busy_o, bus.timeout_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    rand_blk(8);
    clear_mon();
    @(negedge clk);
    bus.start_i = 1'b1; bus.blksize_i = BW'(8); bus.bus_4bit_i = 1'b1; bus.timeout_i = '0; bus.dat_i = 4'hF;
    @(negedge clk);
    bus.start_i = 1'b0; bus.dat_i = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.dat_i = nib_of(k);
      bus.fifo_full_i = (k == 1);
    end
    @(negedge clk);
    bus.fifo_full_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.data_o, bus.wr_o, bus.busy_o, bus.done_o, bus.crc_err_o, bus.timeout_o, bus.overrun_o} !== 10'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=0", {bus.data_o, bus.wr_o, bus.busy_o, bus.done_o,
               bus.crc_err_o, bus.timeout_o, bus.overrun_o});
    end
    n = wr_data_q.size();
    repeat (20) begin
      bus.dat_i = 4'($urandom);
      @(negedge clk);
    end
    checks++;
    if (wr_data_q.size() !== n || done_cnt !== 0) begin
      failures++; $display("FAIL rst_mid_quiet got wr=%0d done=%0d exp wr=%0d done=0", wr_data_q.size(), done_cnt, n);
    end
    rand_blk(3);
    run_block(1'b1, 3, -1, 0, -1, -1, 2, 1'b0);
    checks++;
    if (wr_data_q !== exp_nib_q || wr_cyc_q !== exp_cyc_q || done_cnt !== 1 || done_crc !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_next_block got wr=%0d done=%0d crc=%b exp wr=%0d done=1 crc=0",
               wr_data_q.size(), done_cnt, done_crc, exp_nib_q.size());
    end
  endtask

  task automatic test_ignored();
    logic busy_seen;
    clear_mon();
    busy_seen = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.blksize_i = '0; bus.bus_4bit_i = 1'b1; bus.timeout_i = TW'(2); bus.dat_i = 4'h0;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (6) begin
      busy_seen = busy_seen | bus.busy_o;
      @(negedge clk);
    end
    checks++;
    if (busy_seen !== 1'b0 || done_cnt !== 0) begin
      failures++; $display("FAIL zero_blksize got busy=%b done=%0d exp busy=0 done=0", busy_seen, done_cnt);
    end
    for (int m = 0; m < 2; m++) begin
      rand_blk(5);
      run_block(m == 0, 5, -1, 0, -1, -1, 3, 1'b1);
      checks++;
      if (wr_data_q !== exp_nib_q || wr_cyc_q !== exp_cyc_q || done_cnt !== 1 ||
          done_cyc !== exp_done_cyc || done_crc !== 1'b0) begin
        failures++;
        $display("FAIL start_while_busy_m%0d got wr=%0d done=%0d@%0d crc=%b exp wr=%0d done=1@%0d crc=0",
                 m, wr_data_q.size(), done_cnt, done_cyc, done_crc, exp_nib_q.size(), exp_done_cyc);
      end
    end
  endtask

  task automatic test_random();
    bit four;
    int len;
    for (int r = 0; r < 10; r++) begin
      four = 1'($urandom);
      len  = $urandom_range(1, 16);
      rand_blk(len);
      run_block(four, len, -1, 0, -1, -1, $urandom_range(0, 5), 1'b0);
      checks++;
      if (wr_data_q !== exp_nib_q || wr_cyc_q !== exp_cyc_q) begin
        failures++;
        $display("FAIL rand%0d_stream mode4=%b len=%0d got wr=%0d exp wr=%0d", r, four, len,
                 wr_data_q.size(), exp_nib_q.size());
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== exp_done_cyc ||
          {done_crc, done_tmo, done_ovr, done_busy} !== 4'b0000) begin
        failures++;
        $display("FAIL rand%0d_done got=%0d@%0d st=%b exp=1@%0d st=0000", r, done_cnt, done_cyc,
                 {done_crc, done_tmo, done_ovr, done_busy}, exp_done_cyc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.blksize_i = '0; bus.bus_4bit_i = 1'b0;
    bus.timeout_i = '0; bus.dat_i = 4'hF; bus.fifo_full_i = 1'b0;
    test_reset();
    test_4bit();
    test_1bit();
    test_crc_err();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
